mem_ctrl_unit: RTL and testbench
================================

# mem_ctrl_unit

Parametrised single-port main-memory unit for the Basic Computer datapath: a word-addressed synchronous RAM behind a valid/ready request port and a pipelined read-response port. An internal sweep engine zero-fills the array after reset and on demand. The CPU bus controller is the only requester. Replaces the fixed 4K×16 memory with a block whose width, depth and read latency are configurable.

## Interface
- DATA_W, 16, word width in bits
- ADDR_W, 12, address width; depth N = 2^ADDR_W words
- READ_LATENCY, 1, clock edges from request accept to rsp_valid; legal values 1 or 2 (2 adds an output register)
- CLEAR_ON_RESET, 1, when 1 the array is zero-filled after every reset before requests are accepted
- clock  input  1  single clock, all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- clear  input  1  request a full zero-fill sweep; sampled only in IDLE
- req_valid  input  1  request present
- req_ready  output  1  request accepted on an edge where req_valid && req_ready
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  word address
- req_wdata  input  DATA_W  write data
- rsp_valid  output  1  one-cycle pulse, read data valid; no backpressure
- rsp_rdata  output  DATA_W  read data; holds last value while rsp_valid low
- busy  output  1  high while a clear sweep is in progress

## Operation
- States: START, CLEAR, IDLE. Async reset forces START, clears the sweep counter, the read pipeline valid bits and rsp_rdata to 0.
- START: req_ready=0, busy=0. Next edge goes to CLEAR if CLEAR_ON_RESET=1, else IDLE.
- CLEAR: busy=1, req_ready=0. Each edge writes 0 to the address held in the sweep counter, then increments it. On the edge that writes address N-1, the counter wraps to 0 and the state goes to IDLE.
- IDLE: busy=0, req_ready = !clear. clear=1 in IDLE: the next edge enters CLEAR with the counter at 0. No request is accepted on that edge, even if req_valid=1.
- Write accept: mem[req_addr] <= req_wdata on the accepting edge. No response.
- Read accept: the array is read at req_addr. The data reflects every write accepted on earlier edges.
- Back-to-back accepts are allowed, one per cycle in any mix. Responses return in order, one per read.
- A read issued on the edge after a write to the same address returns the new data.
- Reads in flight when a clear is requested complete normally with the pre-clear data.
- Reset mid-sweep or mid-read: the sweep is abandoned, pending responses are discarded (rsp_valid=0), and the sweep restarts from 0 per CLEAR_ON_RESET. Array contents are not reset asynchronously.
- Address and data widths are exact. There is no out-of-range address.

## Timing
- Reset values: req_ready=0, busy=0, rsp_valid=0, rsp_rdata=0.
- Clear sweep duration: exactly N edges in CLEAR. The first accept is possible on edge N+2 after reset release (1 edge in START, N edges in CLEAR, then IDLE).
- Read latency: rsp_valid is high in the cycle following edge A+READ_LATENCY, where A is the accepting edge.
- req_ready does not depend on req_valid, req_write, req_addr or req_wdata.
- Throughput is 1 request per cycle in IDLE. rsp_valid may be high on consecutive cycles.

## Test plan
Parameters: DATA_W=16, ADDR_W=4, unless stated otherwise.

- Reset release, CLEAR_ON_RESET=1 -> busy=1 for exactly 16 cycles after START; req_ready rises with busy falling; reads of addresses 0..15 all return 0x0000.
- Write 0xBEEF to addr 3, read addr 3 on the next edge (READ_LATENCY=1) -> rsp_valid one cycle after the read accept, rsp_rdata=0xBEEF. Repeat with READ_LATENCY=2 -> response one cycle later.
- Streaming: write addr k=k*0x1111 for k=0..15, then 16 consecutive reads -> 16 consecutive rsp_valid cycles with data in order 0x0000, 0x1111, ..., 0xFFFF.
- clear=1 together with req_valid=1 (write 0x1234 to addr 5) in IDLE -> req_ready=0, no write, busy=1 for 16 cycles; a later read of addr 5 returns 0x0000. Reads issued just before the clear still return their old data.
- Async reset asserted at sweep cycle 7, then released -> outputs 0 immediately, a full 16-cycle sweep restarts; a read in flight at the time of reset produces no rsp_valid.
- CLEAR_ON_RESET=0 -> req_ready=1 one edge after reset release, busy never asserted; write then read of addr 15 with 0xA5A5 returns 0xA5A5.

Source files
------------

// File: rtl/mem_ctrl_unit.sv
// mem_ctrl_unit
// Word-addressed single-port main memory for the Basic Computer datapath.
// Requests arrive on a valid/ready port; reads return in order on a
// pipelined response port with no backpressure. An internal sweep engine
// zero-fills the whole array after reset (when CLEAR_ON_RESET=1) and
// whenever clear is asserted while idle.
//
// Parameters
//   DATA_W         word width in bits
//   ADDR_W         address width, depth = 2**ADDR_W words
//   READ_LATENCY   1 or 2; 2 inserts one extra output pipeline stage
//   CLEAR_ON_RESET 1 = sweep the array to zero after every reset
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous active-high reset
//   clear      request a zero-fill sweep (sampled only in IDLE)
//   req_valid  request present
//   req_ready  request accepted on an edge with req_valid && req_ready
//   req_write  1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   rsp_valid  one-cycle pulse per read, in request order
//   rsp_rdata  read data, holds its value while rsp_valid is low
//   busy       high while a sweep is in progress
module mem_ctrl_unit #(
   parameter int DATA_W         = 16,
   parameter int ADDR_W         = 12,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_CLEAR = 2'd1,
      ST_IDLE  = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic [ADDR_W-1:0]   sweep_cnt_r;
   logic [ADDR_W-1:0]   sweep_cnt_s;
   logic                sweep_we_s;
   logic                busy_r;

   logic                acc_s;
   logic                wr_s;
   logic                rd_s;

   logic                mem_we_s;
   logic [ADDR_W-1:0]   mem_waddr_s;
   logic [DATA_W-1:0]   mem_wdata_s;
   logic [DATA_W-1:0]   mem_r [0:(1 << ADDR_W)-1];
   logic [DATA_W-1:0]   ram_q_r;

   logic                rd_v0_r;
   logic                rd_v1_r;
   logic [DATA_W-1:0]   rd_d1_r;
   logic                out_v_s;
   logic [DATA_W-1:0]   out_d_s;

   // Sequencer next-state, sweep counter update and request handshake.
   always_comb begin
      state_s     = state_r;
      sweep_cnt_s = sweep_cnt_r;
      sweep_we_s  = 1'b0;
      req_ready   = 1'b0;
      case (state_r)
         ST_START: begin
            sweep_cnt_s = {ADDR_W{1'b0}};
            if (CLEAR_ON_RESET != 0) begin
               state_s = ST_CLEAR;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            sweep_we_s = 1'b1;
            if (sweep_cnt_r == LAST_ADDR) begin
               // Last word written this edge: wrap so the next sweep starts at 0.
               sweep_cnt_s = {ADDR_W{1'b0}};
               state_s     = ST_IDLE;
            end else begin
               sweep_cnt_s = sweep_cnt_r + ADDR_W'(1);
               state_s     = ST_CLEAR;
            end
         end
         ST_IDLE: begin
            // A pending clear wins over any request on the same edge.
            req_ready = !clear;
            if (clear) begin
               sweep_cnt_s = {ADDR_W{1'b0}};
               state_s     = ST_CLEAR;
            end else begin
               state_s = ST_IDLE;
            end
         end
         default: begin
            sweep_cnt_s = {ADDR_W{1'b0}};
            state_s     = ST_START;
         end
      endcase
   end

   // Sequencer state, sweep counter and busy flag registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r     <= ST_START;
         sweep_cnt_r <= {ADDR_W{1'b0}};
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         sweep_cnt_r <= sweep_cnt_s;
         busy_r      <= (state_s == ST_CLEAR);
      end
   end

   assign busy  = busy_r;
   assign acc_s = req_valid && req_ready;
   assign wr_s  = acc_s && req_write;
   assign rd_s  = acc_s && !req_write;

   // Single write port shared by the sweep engine and accepted writes.
   always_comb begin
      mem_we_s    = 1'b0;
      mem_waddr_s = req_addr;
      mem_wdata_s = req_wdata;
      if (sweep_we_s) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = sweep_cnt_r;
         mem_wdata_s = {DATA_W{1'b0}};
      end else if (wr_s) begin
         mem_we_s    = 1'b1;
         mem_waddr_s = req_addr;
         mem_wdata_s = req_wdata;
      end else begin
         mem_we_s    = 1'b0;
      end
   end

   // Storage array with a registered read port; contents survive reset.
   always_ff @(posedge clock) begin
      if (mem_we_s) begin
         mem_r[mem_waddr_s] <= mem_wdata_s;
      end
      if (rd_s) begin
         ram_q_r <= mem_r[req_addr];
      end
   end

   // Select the pipeline tap that feeds the output register.
   always_comb begin
      out_v_s = rd_v0_r;
      out_d_s = ram_q_r;
      if (READ_LATENCY == 2) begin
         out_v_s = rd_v1_r;
         out_d_s = rd_d1_r;
      end else begin
         out_v_s = rd_v0_r;
         out_d_s = ram_q_r;
      end
   end

   // Read pipeline valid bits and output registers; reset drops reads in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_v0_r   <= 1'b0;
         rd_v1_r   <= 1'b0;
         rd_d1_r   <= {DATA_W{1'b0}};
         rsp_valid <= 1'b0;
         rsp_rdata <= {DATA_W{1'b0}};
      end else begin
         rd_v0_r   <= rd_s;
         rd_v1_r   <= rd_v0_r;
         if (rd_v0_r) begin
            rd_d1_r <= ram_q_r;
         end
         rsp_valid <= out_v_s;
         if (out_v_s) begin
            rsp_rdata <= out_d_s;
         end
      end
   end

endmodule

// File: tb/tb_mem_ctrl_unit.sv
module tb_mem_ctrl_unit;

   typedef struct {
      logic [15:0] data;
      int          due;
      bit          chk;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        clear = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [3:0]  req_addr = 4'd0;
   logic [15:0] req_wdata = 16'd0;

   logic        req_ready_a, rsp_valid_a, busy_a;
   logic [15:0] rsp_rdata_a;
   logic        req_ready_b, rsp_valid_b, busy_b;
   logic [15:0] rsp_rdata_b;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   exp_t        q_a[$];
   exp_t        q_b[$];
   exp_t        ea;
   exp_t        eb;
   logic [15:0] mem_a [16];
   logic [15:0] mem_b [16];
   bit          known_b [16];
   logic [15:0] last_a = 16'd0;

   // A: latency 1, clears on reset. B: latency 2, no clear on reset.
   mem_ctrl_unit #(.DATA_W(16), .ADDR_W(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_a (
      .clock(clock), .reset(reset), .clear(clear),
      .req_valid(req_valid), .req_ready(req_ready_a), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .busy(busy_a));

   mem_ctrl_unit #(.DATA_W(16), .ADDR_W(4), .READ_LATENCY(2), .CLEAR_ON_RESET(0)) dut_b (
      .clock(clock), .reset(reset), .clear(clear),
      .req_valid(req_valid), .req_ready(req_ready_b), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .busy(busy_b));

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard for A: every response must match the oldest expected one, on time.
   always @(negedge clock) begin
      if (!reset && rsp_valid_a === 1'b1) begin
         checks++;
         if (q_a.size() == 0) begin
            failures++;
            $display("FAIL rsp_a_unexpected data=%h cycle=%0d", rsp_rdata_a, cyc);
         end else begin
            ea = q_a.pop_front();
            last_a = ea.data;
            if (cyc !== ea.due || rsp_rdata_a !== ea.data) begin
               failures++;
               $display("FAIL rsp_a data=%h exp=%h cycle=%0d exp_cycle=%0d",
                        rsp_rdata_a, ea.data, cyc, ea.due);
            end
         end
      end
   end

   // Scoreboard for B; data of never-written words is not compared.
   always @(negedge clock) begin
      if (!reset && rsp_valid_b === 1'b1) begin
         checks++;
         if (q_b.size() == 0) begin
            failures++;
            $display("FAIL rsp_b_unexpected data=%h cycle=%0d", rsp_rdata_b, cyc);
         end else begin
            eb = q_b.pop_front();
            if (cyc !== eb.due || (eb.chk && rsp_rdata_b !== eb.data)) begin
               failures++;
               $display("FAIL rsp_b data=%h exp=%h cycle=%0d exp_cycle=%0d",
                        rsp_rdata_b, eb.data, cyc, eb.due);
            end
         end
      end
   end

   // Drive one request for one cycle; called at a falling edge.
   task automatic issue(input bit wr, input logic [3:0] addr, input logic [15:0] wd,
                        input bit exp_ra, input bit exp_rb);
      exp_t e;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      #1;
      checks++;
      if (req_ready_a !== exp_ra || req_ready_b !== exp_rb) begin
         failures++;
         $display("FAIL req_ready a=%b b=%b exp_a=%b exp_b=%b cycle=%0d",
                  req_ready_a, req_ready_b, exp_ra, exp_rb, cyc);
      end
      if (exp_ra) begin
         if (wr) mem_a[addr] = wd;
         else begin
            e.data = mem_a[addr]; e.due = cyc + 2; e.chk = 1'b1;
            q_a.push_back(e);
         end
      end
      if (exp_rb) begin
         if (wr) begin
            mem_b[addr] = wd; known_b[addr] = 1'b1;
         end else begin
            e.data = mem_b[addr]; e.due = cyc + 3; e.chk = known_b[addr];
            q_b.push_back(e);
         end
      end
      @(negedge clock);
   endtask

   task automatic assert_reset();
      #2;
      reset = 1'b1;
      req_valid = 1'b0;
      clear = 1'b0;
      q_a.delete();
      q_b.delete();
      last_a = 16'd0;
      #1;
      checks++;
      if ({req_ready_a, busy_a, rsp_valid_a, rsp_rdata_a, req_ready_b, busy_b, rsp_valid_b, rsp_rdata_b}
          !== 38'd0) begin
         failures++;
         $display("FAIL reset_outputs a=%b%b%b %h b=%b%b%b %h exp=all zero",
                  req_ready_a, busy_a, rsp_valid_a, rsp_rdata_a,
                  req_ready_b, busy_b, rsp_valid_b, rsp_rdata_b);
      end
      @(negedge clock);
   endtask

   // Release reset and follow n cycles of the post-reset sequence.
   task automatic release_sweep(input int n);
      reset = 1'b0;
      #1;
      checks++;
      if (req_ready_a !== 1'b0 || busy_a !== 1'b0 || req_ready_b !== 1'b0 || busy_b !== 1'b0) begin
         failures++;
         $display("FAIL start_state ready_a=%b busy_a=%b ready_b=%b busy_b=%b exp=0",
                  req_ready_a, busy_a, req_ready_b, busy_b);
      end
      for (int k = 1; k <= n; k++) begin
         @(negedge clock);
         checks++;
         if (busy_a !== (k <= 16) || req_ready_a !== (k >= 17) ||
             busy_b !== 1'b0 || req_ready_b !== 1'b1) begin
            failures++;
            $display("FAIL sweep_k%0d busy_a=%b ready_a=%b busy_b=%b ready_b=%b exp=%b %b 0 1",
                     k, busy_a, req_ready_a, busy_b, req_ready_b, (k <= 16), (k >= 17));
         end
      end
   endtask

   task automatic drain();
      req_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (q_a.size() == 0 && q_b.size() == 0) break;
         @(negedge clock);
      end
      repeat (3) @(negedge clock);
      checks++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         failures++;
         $display("FAIL drain pending_a=%0d pending_b=%0d exp=0", q_a.size(), q_b.size());
      end
      checks++;
      if (rsp_rdata_a !== last_a) begin
         failures++;
         $display("FAIL rdata_hold a=%h exp=%h", rsp_rdata_a, last_a);
      end
   endtask

   task automatic test_reset();
      @(negedge clock);
      assert_reset();
      for (int k = 0; k < 16; k++) mem_a[k] = 16'h0000;
      release_sweep(18);
      for (int k = 0; k < 16; k++) issue(1'b0, 4'(k), 16'h0, 1'b1, 1'b1);
      drain();
   endtask

   task automatic test_write_read();
      issue(1'b1, 4'd3, 16'hBEEF, 1'b1, 1'b1);
      issue(1'b0, 4'd3, 16'h0, 1'b1, 1'b1);
      issue(1'b1, 4'd15, 16'hA5A5, 1'b1, 1'b1);
      issue(1'b0, 4'd15, 16'h0, 1'b1, 1'b1);
      drain();
   endtask

   task automatic test_streaming();
      logic [15:0] v;
      for (int k = 0; k < 16; k++) begin
         v = 16'(k) * 16'h1111;
         issue(1'b1, 4'(k), v, 1'b1, 1'b1);
      end
      for (int k = 0; k < 16; k++) issue(1'b0, 4'(k), 16'h0, 1'b1, 1'b1);
      drain();
   endtask

   task automatic test_clear();
      issue(1'b0, 4'd5, 16'h0, 1'b1, 1'b1);
      clear = 1'b1;
      issue(1'b1, 4'd5, 16'h1234, 1'b0, 1'b0);
      clear = 1'b0;
      req_valid = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         checks++;
         if (busy_a !== (k <= 16) || busy_b !== (k <= 16) ||
             req_ready_a !== (k >= 17) || req_ready_b !== (k >= 17)) begin
            failures++;
            $display("FAIL clear_k%0d busy=%b%b ready=%b%b exp busy=%b ready=%b",
                     k, busy_a, busy_b, req_ready_a, req_ready_b, (k <= 16), (k >= 17));
         end
         @(negedge clock);
      end
      for (int k = 0; k < 16; k++) begin
         mem_a[k] = 16'h0000; mem_b[k] = 16'h0000; known_b[k] = 1'b1;
      end
      issue(1'b0, 4'd5, 16'h0, 1'b1, 1'b1);
      issue(1'b0, 4'd15, 16'h0, 1'b1, 1'b1);
      drain();
   endtask

   task automatic test_reset_midflight();
      issue(1'b1, 4'd3, 16'h3C3C, 1'b1, 1'b1);
      issue(1'b0, 4'd3, 16'h0, 1'b1, 1'b1);
      assert_reset();
      release_sweep(8);
      issue(1'b0, 4'd3, 16'h0, 1'b0, 1'b1);
      assert_reset();
      for (int k = 0; k < 16; k++) mem_a[k] = 16'h0000;
      release_sweep(18);
      issue(1'b0, 4'd3, 16'h0, 1'b1, 1'b1);
      issue(1'b0, 4'd9, 16'h0, 1'b1, 1'b1);
      drain();
   endtask

   initial begin
      for (int k = 0; k < 16; k++) begin
         mem_a[k] = 16'h0000; mem_b[k] = 16'h0000; known_b[k] = 1'b0;
      end
      test_reset();
      test_write_read();
      test_streaming();
      test_clear();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
